// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: N:1 select multiplexer feeding a registered ready/valid
// output stage backed by a one-beat skid register. The select is resolved
// when a beat is accepted, so later input changes never affect stored beats.
// An out-of-range select yields FILL and raises a sticky error flag.
module sel_mux_pipe #(
  parameter int              WIDTH  = 5,
  parameter int              NUM_IN = 3,
  parameter int              SELW   = 2,
  parameter logic [WIDTH-1:0] FILL  = {WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]         in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SELW-1:0]         out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // True when the select does not address an existing channel.
  function automatic logic sel_illegal(input logic [SELW-1:0] sel);
    return (int'(sel) >= NUM_IN);
  endfunction

  // Picks the addressed channel, or FILL when the select is out of range.
  function automatic logic [WIDTH-1:0] select_word(
    input logic [NUM_IN*WIDTH-1:0] data,
    input logic [SELW-1:0]         sel
  );
    logic [WIDTH-1:0] word;
    word = FILL;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) begin
        word = data[k*WIDTH +: WIDTH];
      end
    end
    return word;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] main_data_r;
  logic [SELW-1:0]  main_sel_r;
  logic [WIDTH-1:0] skid_data_r;
  logic [SELW-1:0]  skid_sel_r;
  logic             sel_err_r;

  logic             accept_s;
  logic             pop_s;
  logic [WIDTH-1:0] in_word_s;
  logic             load_main_s;
  logic             load_skid_s;
  logic             main_from_skid_s;

  assign accept_s = in_valid && in_ready_r;
  assign pop_s    = out_valid_r && out_ready;

  // Resolve the selected word for the beat currently presented upstream.
  always_comb begin
    in_word_s = select_word(in_data, in_sel);
  end

  // Next-state and storage-control decode for the EMPTY/ONE/TWO occupancy FSM.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_s      = 1'b0;
    load_skid_s      = 1'b0;
    main_from_skid_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          load_main_s = 1'b1;
          state_nxt_s = ST_ONE;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && pop_s) begin
          load_main_s = 1'b1;
          state_nxt_s = ST_ONE;
        end else if (accept_s) begin
          load_skid_s = 1'b1;
          state_nxt_s = ST_TWO;
        end else if (pop_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (pop_s) begin
          main_from_skid_s = 1'b1;
          state_nxt_s      = ST_ONE;
        end else begin
          state_nxt_s = ST_TWO;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // State register plus flopped handshake outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      in_ready_r  <= (state_nxt_s != ST_TWO);
    end
  end

  // Main and skid data registers; main refills from skid when draining TWO.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data_r <= {WIDTH{1'b0}};
      main_sel_r  <= {SELW{1'b0}};
      skid_data_r <= {WIDTH{1'b0}};
      skid_sel_r  <= {SELW{1'b0}};
    end else begin
      if (main_from_skid_s) begin
        main_data_r <= skid_data_r;
        main_sel_r  <= skid_sel_r;
      end else if (load_main_s) begin
        main_data_r <= in_word_s;
        main_sel_r  <= in_sel;
      end else begin
        main_data_r <= main_data_r;
        main_sel_r  <= main_sel_r;
      end
      if (load_skid_s) begin
        skid_data_r <= in_word_s;
        skid_sel_r  <= in_sel;
      end else begin
        skid_data_r <= skid_data_r;
        skid_sel_r  <= skid_sel_r;
      end
    end
  end

  // Sticky select-error flag; a new illegal accept beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_r <= 1'b0;
    end else if (accept_s && sel_illegal(in_sel)) begin
      sel_err_r <= 1'b1;
    end else if (err_clr) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= sel_err_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_data_r;
  assign out_sel   = main_sel_r;
  assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Self-checking bench for sel_mux_pipe (WIDTH=5, NUM_IN=3, FILL=0).
// A capacity-two queue with a sticky error bit serves as the reference.
module tb_sel_mux_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;
  logic        err_clr;

  sel_mux_pipe #(.WIDTH(5), .NUM_IN(3), .SELW(2), .FILL(5'h00)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [4:0] data;
  } beat_t;

  typedef struct packed {
    logic [1:0] sel;
    logic       valid;
    logic       oready;
    logic       clr;
    logic [4:0] exp_data;
    logic [1:0] exp_sel;
    logic       exp_valid;
    logic       exp_iready;
    logic       exp_err;
  } vec_t;

  beat_t q[$];
  logic  m_err;
  int    accepted;
  int    vectors;
  int    miscompares;
  logic  stall_prev;
  logic [4:0] stall_data;
  logic [1:0] stall_sel;

  function automatic logic [4:0] ref_word(input logic [14:0] d, input logic [1:0] s);
    if (s >= 2'd3) return 5'h00;
    return 5'(d >> (32'(s) * 5));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the reference with the sampled inputs, return at negedge.
  task automatic cycle();
    stall_prev = out_valid && !out_ready && !rst;
    stall_data = out_data;
    stall_sel  = out_sel;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      logic acc, pp;
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && out_ready;
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back('{sel: in_sel, data: ref_word(in_data, in_sel)});
        accepted++;
      end
      if (acc && in_sel >= 2'd3) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
    @(negedge clk);
    if (stall_prev) begin
      chk("stable_data", 32'(out_data), 32'(stall_data));
      chk("stable_sel", 32'(out_sel), 32'(stall_sel));
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, "_iready"}, 32'(in_ready), 32'(q.size() < 2));
    chk({tag, "_err"}, 32'(sel_err), 32'(m_err));
    if (q.size() > 0) begin
      chk({tag, "_data"}, 32'(out_data), 32'(q[0].data));
      chk({tag, "_sel"}, 32'(out_sel), 32'(q[0].sel));
    end
  endtask

  vec_t vecs[8];

  initial begin
    vectors = 0; miscompares = 0; accepted = 0; m_err = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; out_ready = 1'b0; err_clr = 1'b0;
    in_data = {5'h1E, 5'h11, 5'h03};

    // Reset state
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_iready", 32'(in_ready), 32'd1);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_err", 32'(sel_err), 32'd0);

    // Basic and illegal select: {sel,valid,oready,clr, data,sel,valid,iready,err}
    vecs[0] = '{2'd0, 1'b1, 1'b1, 1'b0, 5'h03, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{2'd1, 1'b1, 1'b1, 1'b0, 5'h11, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{2'd2, 1'b1, 1'b1, 1'b0, 5'h1E, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{2'd3, 1'b1, 1'b1, 1'b0, 5'h00, 2'd3, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{2'd0, 1'b0, 1'b1, 1'b1, 5'h00, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'd3, 1'b1, 1'b1, 1'b1, 5'h00, 2'd3, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{2'd1, 1'b1, 1'b1, 1'b0, 5'h11, 2'd1, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{2'd0, 1'b0, 1'b1, 1'b1, 5'h00, 2'd0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      in_sel = vecs[i].sel; in_valid = vecs[i].valid;
      out_ready = vecs[i].oready; err_clr = vecs[i].clr;
      cycle();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_iready", i), 32'(in_ready), 32'(vecs[i].exp_iready));
      chk($sformatf("vec%0d_err", i), 32'(sel_err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
        chk($sformatf("vec%0d_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
      end
    end
    err_clr = 1'b0;

    // Backpressure and skid: A=sel0, B=sel1, C=sel2
    in_valid = 1'b1; in_sel = 2'd0; out_ready = 1'b0; cycle(); check_model("bp_a");
    in_sel = 2'd1; cycle(); check_model("bp_b");
    chk("bp_full_iready", 32'(in_ready), 32'd0);
    chk("bp_hold_a", 32'(out_data), 32'h03);
    in_sel = 2'd2; cycle(); check_model("bp_c_blocked");
    chk("bp_still_a", 32'(out_data), 32'h03);
    out_ready = 1'b1; cycle(); check_model("bp_pop_a");
    chk("bp_out_b", 32'(out_data), 32'h11);
    cycle(); check_model("bp_pop_b");
    chk("bp_out_c", 32'(out_data), 32'h1E);
    in_valid = 1'b0; cycle(); check_model("bp_pop_c");
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Full throughput
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_data = 15'($urandom); in_sel = 2'($urandom_range(0, 2));
      cycle();
      chk("thr_iready", 32'(in_ready), 32'd1);
      chk("thr_valid", 32'(out_valid), 32'd1);
      check_model("thr");
    end
    in_valid = 1'b0; cycle(); check_model("thr_drain");

    // Random stall
    begin
      int target, n;
      target = accepted + 500;
      n = 0;
      while (accepted < target && n < 5000) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        err_clr   = ($urandom_range(0, 9) == 0);
        in_data   = 15'($urandom);
        in_sel    = 2'($urandom_range(0, 3));
        cycle();
        check_model("rnd");
        n++;
      end
      chk("rnd_budget", 32'(accepted >= target), 32'd1);
    end
    err_clr = 1'b0;

    // Reset mid-operation while in TWO with sel_err set
    out_ready = 1'b1; in_valid = 1'b0; cycle(); cycle();
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd3; cycle();
    in_sel = 2'd1; cycle(); check_model("pre_rst");
    chk("pre_rst_two", 32'(in_ready), 32'd0);
    rst = 1'b1; in_sel = 2'd2; cycle();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_iready", 32'(in_ready), 32'd1);
    chk("mid_rst_err", 32'(sel_err), 32'd0);
    in_data = {5'h0A, 5'h15, 5'h07}; in_sel = 2'd1; out_ready = 1'b1; cycle();
    check_model("post_rst");
    chk("post_rst_first", 32'(out_data), 32'h15);
    in_valid = 1'b0; cycle(); check_model("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sel_mux_pipe.md
# sel_mux_pipe

Parametrised N:1 select multiplexer with a registered ready/valid output stage and a two-entry skid buffer. It replaces fixed-width combinational 3:1 selectors on register-address and operand paths, so mux outputs can be registered without losing throughput. An out-of-range select never produces an undefined value: it emits a deterministic fill word and raises a sticky error flag.

## Interface

**Parameters**
- WIDTH, default 5: data width of each input channel and of the output.
- NUM_IN, default 3: number of input channels; legal range 2..16.
- SELW, default 2: select width; must be at least clog2(NUM_IN).
- FILL, default 0: output word emitted for an out-of-range select.

**Ports**
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_data, input, NUM_IN*WIDTH: flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- in_sel, input, SELW: channel select, sampled on accept.
- in_valid, input, 1: upstream beat valid.
- in_ready, output, 1: block can accept a beat; registered.
- out_data, output, WIDTH: selected word.
- out_sel, output, SELW: select value used for the current out_data.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: downstream accepts.
- sel_err, output, 1: sticky flag; at least one accepted beat had in_sel >= NUM_IN.
- err_clr, input, 1: clears sel_err.

## Operation

**Transfers**
- Accept occurs when in_valid && in_ready.
- Pop occurs when out_valid && out_ready.
- On accept, the word is the selected channel if in_sel < NUM_IN, otherwise FILL. That word and in_sel are stored.
- Selection happens only at accept. Later changes to in_data do not affect stored beats.

**Storage**
- Main register drives out_data and out_sel.
- Skid register holds one overflow beat.

**State machine (EMPTY / ONE / TWO)**
- EMPTY: out_valid=0, in_ready=1.
  - Accept: load main, go to ONE.
- ONE: out_valid=1, in_ready=1.
  - Accept and pop: load main with the new beat, stay in ONE.
  - Accept only: load skid, go to TWO.
  - Pop only: go to EMPTY.
  - Neither: hold.
- TWO: out_valid=1, in_ready=0.
  - Pop: main takes skid, go to ONE.
  - in_valid is ignored; no accept is possible.

**Error flag**
- sel_err sets on any accept with in_sel >= NUM_IN.
- err_clr clears sel_err.
- If set and clear occur in the same cycle, set wins.
- Beats with an illegal select still flow through in order, carrying FILL.

**Ordering and loss**
- Strict FIFO order.
- No beat is ever dropped or duplicated.

**Reset**
- Reset forces EMPTY.
- Reset values: out_valid=0, in_ready=1, out_data=0, out_sel=0, sel_err=0.
- Skid contents are discarded.
- Reset during TWO loses both stored beats; this is by design.
- Beats presented in the reset cycle are not accepted.

## Timing

- Latency is 1 cycle: a beat accepted at edge N appears on out_data/out_valid after edge N, i.e. in cycle N+1.
- Throughput is 1 beat per cycle when out_ready is held high.
- in_ready comes from a flop. It depends only on state (low in TWO), never combinationally on out_ready.
- When out_ready deasserts, in_ready falls one cycle later. The skid absorbs the one beat in flight.
- out_data and out_sel are stable while out_valid=1 and out_ready=0.
- sel_err reflects an illegal accept at edge N starting in cycle N+1.

## Test plan

All scenarios use WIDTH=5, NUM_IN=3, FILL=0.

- **Basic select.** Channels = {5'h03, 5'h11, 5'h1E}, in_sel = 0, 1, 2 on consecutive cycles, out_ready=1 → out_data shows 03, 11, 1E one cycle later each; out_sel shows 0, 1, 2; sel_err stays 0.
- **Illegal select.** in_sel=3 accepted → out_data=00, out_sel=3, sel_err=1 from the next cycle. err_clr pulsed alone → sel_err=0. err_clr pulsed in the same cycle as another sel=3 accept → sel_err stays 1.
- **Backpressure and skid.** Stream beats A, B, C with out_ready=0 from the cycle after A is accepted → A held on out_data, B in skid, in_ready=0, C not accepted. Raise out_ready → A, B, C delivered in order with no loss or duplication.
- **Full throughput.** 20 back-to-back beats with out_ready=1 → 20 outputs on consecutive cycles; in_ready never drops.
- **Random stall.** in_valid and out_ready each toggled randomly at about 50%, 500 beats → scoreboard match in order; out_data stable whenever out_valid && !out_ready.
- **Reset mid-operation.** Assert rst while in TWO → next cycle out_valid=0, in_ready=1, sel_err=0. The first beat accepted after reset is the first beat delivered.
